// File: rtl/elevator_request_queue.sv
// Elevator request queue: an ordered list of distinct pending floor requests.
// Each cycle a served floor may be removed, with the later entries closing
// the gap, and then a new request may be appended. An add that cannot be
// accepted produces a one-cycle drop pulse. Every output comes from flops.
module elevator_request_queue #(
  parameter int DEPTH   = 4,
  parameter int FLOOR_W = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         add_valid,
  input  logic [FLOOR_W-1:0]           add_floor,
  input  logic                         rm_valid,
  input  logic [FLOOR_W-1:0]           rm_floor,
  output logic [FLOOR_W-1:0]           head_floor,
  output logic                         head_valid,
  output logic [$clog2(DEPTH+1)-1:0]   tail,
  output logic                         full,
  output logic [DEPTH*FLOOR_W-1:0]     queue_flat,
  output logic                         drop
);

  localparam int TAIL_W = $clog2(DEPTH+1);

  logic [FLOOR_W-1:0] slot_q    [DEPTH];
  logic [FLOOR_W-1:0] slot_d    [DEPTH];
  logic [TAIL_W-1:0]  tail_q;
  logic [TAIL_W-1:0]  tail_d;
  logic               drop_q;
  logic               drop_d;

  logic [FLOOR_W-1:0] slot_ext  [DEPTH+1];
  logic [FLOOR_W-1:0] slot_post [DEPTH];
  logic [DEPTH-1:0]   match_vec;
  logic [DEPTH-1:0]   shift_vec;
  logic               shift_run;
  logic               any_match;
  logic [TAIL_W-1:0]  tail_post;
  logic               dup_hit;
  logic               add_ok;

  // Removal happens first: the matching slot and everything above it slide down one place.
  always_comb begin
    slot_ext[DEPTH] = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot_ext[k] = slot_q[k];
    end
    shift_run = 1'b0;
    match_vec = '0;
    shift_vec = '0;
    for (int k = 0; k < DEPTH; k++) begin
      match_vec[k] = rm_valid && (TAIL_W'(k) < tail_q) && (slot_q[k] == rm_floor);
      shift_run    = shift_run | match_vec[k];
      shift_vec[k] = shift_run;
      slot_post[k] = shift_vec[k] ? slot_ext[k+1] : slot_ext[k];
    end
    any_match = |match_vec;
    tail_post = any_match ? (tail_q - TAIL_W'(1)) : tail_q;
  end

  // The add is then judged against the post-removal queue and appended at its end.
  always_comb begin
    dup_hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((TAIL_W'(k) < tail_post) && (slot_post[k] == add_floor)) begin
        dup_hit = 1'b1;
      end
    end
    add_ok = add_valid && !dup_hit && !(rm_valid && (add_floor == rm_floor)) &&
             (tail_post < TAIL_W'(DEPTH));
    for (int k = 0; k < DEPTH; k++) begin
      slot_d[k] = (add_ok && (TAIL_W'(k) == tail_post)) ? add_floor : slot_post[k];
    end
    tail_d = add_ok ? (tail_post + TAIL_W'(1)) : tail_post;
    drop_d = add_valid && !add_ok;
  end

  // State register; reset wins over any request arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_q[k] <= '0;
      end
      tail_q <= '0;
      drop_q <= 1'b0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_q[k] <= slot_d[k];
      end
      tail_q <= tail_d;
      drop_q <= drop_d;
    end
  end

  // Outputs are straight decodes of the registered state.
  always_comb begin
    queue_flat = '0;
    for (int k = 0; k < DEPTH; k++) begin
      queue_flat[k*FLOOR_W +: FLOOR_W] = slot_q[k];
    end
    head_floor = slot_q[0];
    head_valid = (tail_q != '0);
    full       = (tail_q == TAIL_W'(DEPTH));
    tail       = tail_q;
    drop       = drop_q;
  end

endmodule

// File: tb/tb_elevator_request_queue.sv
// Self-checking bench for elevator_request_queue: directed scenarios with
// literal expectations, then randomized traffic against a queue-based model.
module tb_elevator_request_queue;

  logic       clk;
  logic       rst_n;
  logic       add_valid;
  logic [1:0] add_floor;
  logic       rm_valid;
  logic [1:0] rm_floor;
  logic [1:0] head_floor;
  logic       head_valid;
  logic [2:0] tail;
  logic       full;
  logic [7:0] queue_flat;
  logic       drop;

  int assertCount = 0;
  int failCount   = 0;
  bit checkEnable = 0;

  int mq[$];
  bit mDrop = 0;

  elevator_request_queue #(.DEPTH(4), .FLOOR_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .add_valid  (add_valid),
    .add_floor  (add_floor),
    .rm_valid   (rm_valid),
    .rm_floor   (rm_floor),
    .head_floor (head_floor),
    .head_valid (head_valid),
    .tail       (tail),
    .full       (full),
    .queue_flat (queue_flat),
    .drop       (drop)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] modelFlat();
    logic [7:0] f;
    f = '0;
    for (int i = 0; i < mq.size(); i++) f[2*i +: 2] = 2'(mq[i]);
    return f;
  endfunction

  // Reference behaviour: remove the served floor, then append a new distinct floor if room remains.
  function automatic void modelStep(input bit rstn, input bit av, input int af, input bit rv, input int rf);
    bit accept;
    bit present;
    if (!rstn) begin
      mq.delete();
      mDrop = 0;
      return;
    end
    if (rv) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i] == rf) begin
          mq.delete(i);
          break;
        end
      end
    end
    present = 0;
    foreach (mq[i]) if (mq[i] == af) present = 1;
    accept = av && !present && !(rv && af == rf) && (mq.size() < 4);
    if (accept) mq.push_back(af);
    mDrop = av && !accept;
  endfunction

  // Drive one cycle of inputs, then advance the model on the same edge as the DUT.
  task automatic applyStimulus(input bit rstn, input bit av, input int af, input bit rv, input int rf);
    @(negedge clk);
    rst_n     = rstn;
    add_valid = av;
    add_floor = 2'(af);
    rm_valid  = rv;
    rm_floor  = 2'(rf);
    @(posedge clk);
    modelStep(rstn, av, af, rv, rf);
    checkEnable = 1;
  endtask

  task automatic idle();
    applyStimulus(1, 0, 0, 0, 0);
  endtask

  // Literal check of DUT and model state shortly after the edge.
  task automatic checkLiteral(input string name, input logic [7:0] flat, input int t, input bit d);
    #1;
    checkOutput({name, "_flat"}, queue_flat, flat);
    checkOutput({name, "_tail"}, tail, t);
    checkOutput({name, "_drop"}, drop, d);
    checkOutput({name, "_model_flat"}, modelFlat(), flat);
    checkOutput({name, "_model_tail"}, mq.size(), t);
  endtask

  // Every cycle, compare all outputs against the model.
  always @(negedge clk) begin
    if (checkEnable) begin
      checkOutput("cyc_tail", tail, mq.size());
      checkOutput("cyc_flat", queue_flat, modelFlat());
      checkOutput("cyc_head_floor", head_floor, (mq.size() != 0) ? mq[0] : 0);
      checkOutput("cyc_head_valid", head_valid, mq.size() != 0);
      checkOutput("cyc_full", full, mq.size() == 4);
      checkOutput("cyc_drop", drop, mDrop);
    end
  end

  initial begin
    rst_n = 0; add_valid = 0; add_floor = 0; rm_valid = 0; rm_floor = 0;

    applyStimulus(0, 0, 0, 0, 0);
    checkLiteral("reset", 8'h00, 0, 0);
    #1 checkOutput("reset_head_valid", head_valid, 0);
    checkOutput("reset_full", full, 0);

    applyStimulus(1, 1, 1, 0, 0);
    applyStimulus(1, 1, 3, 0, 0);
    applyStimulus(1, 1, 2, 0, 0);
    checkLiteral("add132", 8'b00_10_11_01, 3, 0);
    checkOutput("add132_head", head_floor, 1);

    applyStimulus(1, 0, 0, 1, 3);
    checkLiteral("rm3", 8'b00_00_10_01, 2, 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkLiteral("rm0_nomatch", 8'b00_00_10_01, 2, 0);

    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0);
    applyStimulus(1, 1, 3, 0, 0);
    applyStimulus(1, 1, 2, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkLiteral("fill", 8'b00_10_11_01, 4, 0);
    checkOutput("fill_full", full, 1);
    applyStimulus(1, 1, 2, 0, 0);
    checkLiteral("full_dup", 8'b00_10_11_01, 4, 1);
    idle();
    checkLiteral("drop_one_cycle", 8'b00_10_11_01, 4, 0);
    applyStimulus(1, 1, 2, 1, 1);
    checkLiteral("rm1_add2_dup", 8'b00_00_10_11, 3, 1);
    applyStimulus(1, 1, 1, 1, 3);
    checkLiteral("rm3_add1", 8'b00_01_00_10, 3, 0);

    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 1, 2, 0, 0);
    applyStimulus(1, 1, 2, 1, 2);
    checkLiteral("rm2_add2", 8'h00, 0, 1);
    checkOutput("rm2_add2_head_valid", head_valid, 0);

    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0);
    applyStimulus(1, 1, 3, 0, 0);
    applyStimulus(0, 1, 2, 0, 0);
    checkLiteral("reset_mid", 8'h00, 0, 0);
    applyStimulus(1, 1, 3, 0, 0);
    checkLiteral("add_after_reset", 8'b00_00_00_11, 1, 0);

    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 63) != 0,
                    1'($urandom_range(0, 1)), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
